// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// mux selects, trap causes and the decode-dispatch helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC_R,
        R_WB,
        EXEC_I,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ori;
        logic       lui;
        logic       halted;
    } ctrl_t;

    // State that follows DECODE; anything unrecognised is an illegal-opcode trap.
    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:             return MEM_ADDR;
            OP_RTYPE:                 return EXEC_R;
            OP_ADDI, OP_ORI, OP_LUI:  return EXEC_I;
            OP_BEQ:                   return BRANCH;
            OP_J:                     return JUMP;
            default:                  return HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait.sv
// mc_mem_wait: counts stalled cycles of a pending memory access and flags a
// timeout on the cycle the count would reach WAIT_LIMIT with no mem_ready.
module mc_mem_wait #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CNT_BITS = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_BITS-1:0] LIMIT_M1 = CNT_BITS'(WAIT_LIMIT - 1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // mem_ready wins over the limit: a completing access never times out.
    assign timeout = busy && !mem_ready && (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d = '0;
        if (busy && !mem_ready && !timeout) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory stall handshake and sticky HALT trap.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
`ifdef INSTR_COUNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             ori,
    output logic             lui,
    output logic             halted,
    output logic [1:0]       trap_cause
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    state_e     state_q, state_d;
    logic [1:0] trap_q, trap_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl, ctrl_out;
    logic       busy;
    logic       timeout;

    // zero only qualifies pc_write_cond inside the datapath; the FSM never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    mc_mem_wait #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_mem_wait (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        op_d    = op_q;
        busy    = 1'b0;
        ctrl    = '0;
        case (state_q)
            FETCH: begin
                busy           = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                op_d           = opcode;
                state_d        = decode_next(opcode);
                if (state_d == HALT) begin
                    trap_d = TRAP_ILLEGAL;
                end
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                busy           = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (state_q == MEM_RD);
                ctrl.mem_write = (state_q == MEM_WR);
                if (mem_ready) begin
                    state_d = (state_q == MEM_RD) ? MEM_WB : FETCH;
                end else if (timeout) begin
                    state_d = HALT;
                    trap_d  = TRAP_TIMEOUT;
                end
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = FETCH;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = R_WB;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = FETCH;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ori       = (op_q == OP_ORI);
                ctrl.lui       = (op_q == OP_LUI);
                state_d        = I_WB;
            end
            I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.ori       = (op_q == OP_ORI);
                ctrl.lui       = (op_q == OP_LUI);
                state_d        = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = FETCH;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = FETCH;
            end
            default: begin
                ctrl.halted = 1'b1;
                state_d     = HALT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            trap_q  <= TRAP_NONE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            op_q    <= op_d;
        end
    end

    // Reset forces every output low in the same cycle, aborting any request.
    assign ctrl_out      = rst ? '0 : ctrl;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;
    assign ori           = ctrl_out.ori;
    assign lui           = ctrl_out.lui;
    assign halted        = ctrl_out.halted;
    assign trap_cause    = rst ? TRAP_NONE : trap_q;

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_comb begin
        retire = 1'b0;
        if (state_d == FETCH) begin
            case (state_q)
                MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
                default:                                  retire = 1'b0;
            endcase
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = rst ? '0 : retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: cycle-by-cycle vector table plus
// directed trap/timeout sequences; retired counter checked when INSTR_COUNT_EN is set.
module tb_multicycle_control;

    localparam int WL = 4;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
        logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ori, lui, halted;
        logic [1:0] trap_cause;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, BAD = 6'b111111;

    localparam out_t E_ZERO       = '0;
    localparam out_t E_FETCH_WAIT = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
    localparam out_t E_FETCH_GO   = '{pc_write:1'b1, mem_read:1'b1, ir_write:1'b1,
                                      alu_src_b:2'b01, default:'0};
    localparam out_t E_DECODE     = '{alu_src_b:2'b11, default:'0};
    localparam out_t E_MEM_ADDR   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam out_t E_MEM_RD     = '{i_or_d:1'b1, mem_read:1'b1, default:'0};
    localparam out_t E_MEM_WB     = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
    localparam out_t E_MEM_WR     = '{i_or_d:1'b1, mem_write:1'b1, default:'0};
    localparam out_t E_EXEC_R     = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
    localparam out_t E_R_WB       = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
    localparam out_t E_EXEC_I     = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam out_t E_EXEC_ORI   = '{alu_src_a:1'b1, alu_src_b:2'b10, ori:1'b1, default:'0};
    localparam out_t E_EXEC_LUI   = '{alu_src_a:1'b1, alu_src_b:2'b10, lui:1'b1, default:'0};
    localparam out_t E_I_WB       = '{reg_write:1'b1, default:'0};
    localparam out_t E_I_WB_ORI   = '{reg_write:1'b1, ori:1'b1, default:'0};
    localparam out_t E_I_WB_LUI   = '{reg_write:1'b1, lui:1'b1, default:'0};
    localparam out_t E_BRANCH     = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1,
                                      pc_source:2'b01, default:'0};
    localparam out_t E_JUMP       = '{pc_write:1'b1, pc_source:2'b10, default:'0};
    localparam out_t E_HALT_ILL   = '{halted:1'b1, trap_cause:2'b01, default:'0};
    localparam out_t E_HALT_TO    = '{halted:1'b1, trap_cause:2'b10, default:'0};

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ori, lui, halted;
    logic [1:0] alu_src_b, alu_op, pc_source, trap_cause;
    out_t       act;
`ifdef INSTR_COUNT_EN
    logic [31:0] retired;
`endif

    int tests  = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ori           (ori),
        .lui           (lui),
        .halted        (halted),
        .trap_cause    (trap_cause)
`ifdef INSTR_COUNT_EN
        ,
        .retired       (retired)
`endif
    );

    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, ori, lui, halted, trap_cause};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge, then advance.
    task automatic run(input string name, input logic r, input logic [5:0] op,
                       input logic z, input logic rdy, input out_t exp);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        @(negedge clk);
        check(name, 32'(act), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic [5:0] op, input logic z,
                                input logic rdy, input out_t exp);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset, then R-type
        add(1, RT, 0, 1, E_ZERO);
        add(1, RT, 0, 1, E_ZERO);
        add(0, RT, 0, 1, E_FETCH_GO);
        add(0, RT, 0, 0, E_DECODE);
        add(0, RT, 0, 1, E_EXEC_R);
        add(0, RT, 0, 0, E_R_WB);
        // lw with three stall cycles; ready arrives exactly on the limit cycle
        add(0, LW, 0, 1, E_FETCH_GO);
        add(0, LW, 0, 0, E_DECODE);
        add(0, LW, 0, 1, E_MEM_ADDR);
        add(0, LW, 0, 0, E_MEM_RD);
        add(0, LW, 0, 0, E_MEM_RD);
        add(0, LW, 0, 0, E_MEM_RD);
        add(0, LW, 0, 1, E_MEM_RD);
        add(0, LW, 0, 1, E_MEM_WB);
        add(0, BEQ, 1, 0, E_FETCH_WAIT);
        add(0, BEQ, 1, 1, E_FETCH_GO);
        // beq taken and not taken look identical to the FSM
        add(0, BEQ, 1, 0, E_DECODE);
        add(0, BEQ, 1, 0, E_BRANCH);
        add(0, BEQ, 0, 1, E_FETCH_GO);
        add(0, BEQ, 0, 0, E_DECODE);
        add(0, BEQ, 0, 0, E_BRANCH);
        // lui, ori, j, addi
        add(0, LUI, 0, 1, E_FETCH_GO);
        add(0, LUI, 0, 0, E_DECODE);
        add(0, LUI, 0, 0, E_EXEC_LUI);
        add(0, LUI, 0, 0, E_I_WB_LUI);
        add(0, ORI, 0, 1, E_FETCH_GO);
        add(0, ORI, 0, 0, E_DECODE);
        add(0, ORI, 0, 1, E_EXEC_ORI);
        add(0, ORI, 0, 0, E_I_WB_ORI);
        add(0, JMP, 0, 1, E_FETCH_GO);
        add(0, JMP, 0, 0, E_DECODE);
        add(0, JMP, 0, 0, E_JUMP);
        add(0, ADDI, 0, 1, E_FETCH_GO);
        add(0, ADDI, 0, 0, E_DECODE);
        add(0, ADDI, 0, 0, E_EXEC_I);
        add(0, ADDI, 0, 0, E_I_WB);
        // sw completing immediately
        add(0, SW, 0, 1, E_FETCH_GO);
        add(0, SW, 0, 0, E_DECODE);
        add(0, SW, 0, 0, E_MEM_ADDR);
        add(0, SW, 0, 1, E_MEM_WR);
        // reset in the middle of a stalled lw read, no re-issue afterwards
        add(0, LW, 0, 1, E_FETCH_GO);
        add(0, LW, 0, 0, E_DECODE);
        add(0, LW, 0, 0, E_MEM_ADDR);
        add(0, LW, 0, 0, E_MEM_RD);
        add(1, LW, 0, 0, E_ZERO);
        add(0, LW, 0, 0, E_FETCH_WAIT);
        add(0, LW, 0, 1, E_FETCH_GO);

        for (int i = 0; i < vecs.size(); i++) begin
            run($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].zero,
                vecs[i].rdy, vecs[i].exp);
        end

        // illegal opcode: sticky HALT ignores mem_ready, reset clears the trap
        run("ill_decode", 0, BAD, 0, 0, E_DECODE);
        for (int i = 0; i < 4; i++) begin
            run($sformatf("ill_halt%0d", i), 0, BAD, 0, 1'(i % 2 == 0), E_HALT_ILL);
        end
        run("ill_rst", 1, BAD, 0, 1, E_ZERO);
        run("ill_fetch", 0, SW, 0, 1, E_FETCH_GO);

        // sw timeout: four stalled cycles then HALT with cause 10
        run("to_decode", 0, SW, 0, 0, E_DECODE);
        run("to_addr", 0, SW, 0, 0, E_MEM_ADDR);
        for (int i = 0; i < WL; i++) begin
            run($sformatf("to_wr%0d", i), 0, SW, 0, 0, E_MEM_WR);
        end
        for (int i = 0; i < 3; i++) begin
            run($sformatf("to_halt%0d", i), 0, SW, 0, 1'(i == 1), E_HALT_TO);
        end

        // sw rescued by mem_ready on the limit cycle
        run("rs_rst", 1, SW, 0, 1, E_ZERO);
        run("rs_fetch", 0, SW, 0, 1, E_FETCH_GO);
        run("rs_decode", 0, SW, 0, 0, E_DECODE);
        run("rs_addr", 0, SW, 0, 0, E_MEM_ADDR);
        for (int i = 0; i < WL - 1; i++) begin
            run($sformatf("rs_wr%0d", i), 0, SW, 0, 0, E_MEM_WR);
        end
`ifdef INSTR_COUNT_EN
        check("retired_before", retired, 32'd0);
`endif
        run("rs_wr_done", 0, SW, 0, 1, E_MEM_WR);
`ifdef INSTR_COUNT_EN
        check("retired_after", retired, 32'd1);
`endif
        // fetch timeout right after the rescue
        for (int i = 0; i < WL; i++) begin
            run($sformatf("fto_fetch%0d", i), 0, SW, 0, 0, E_FETCH_WAIT);
        end
        run("fto_halt0", 0, SW, 0, 1, E_HALT_TO);
        run("fto_halt1", 0, SW, 0, 0, E_HALT_TO);
`ifdef INSTR_COUNT_EN
        check("retired_frozen", retired, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS datapath. It replaces the single-cycle decoder for the Lab-4 core.
- Drives PC, IR, register-file, ALU-mux and memory-port enables per state.
- Stalls on a variable-latency unified memory via a req/ready handshake.
- Traps illegal opcodes and memory timeouts into a sticky HALT state.

Parameters:
- WAIT_LIMIT, 16: maximum cycles any memory state waits for mem_ready before a timeout trap; must be ≥1.
- CNT_W, 32: width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE and held by the IR.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero (beq).
- i_or_d  out  1  memory address select: PC(0), ALUOut(1).
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  write register: rt(0), rd(1).
- mem_to_reg  out  1  write data: ALUOut(0), MDR(1).
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A input: PC(0), A reg(1).
- alu_src_b  out  2  ALU B input: B reg(00), 4(01), sign-ext imm(10), sign-ext imm<<2(11).
- alu_op  out  2  add(00), sub(01), funct(10).
- pc_source  out  2  PC+4 ALU(00), ALUOut(01), jump target(10).
- ori  out  1  zero-extend immediate, ALU OR.
- lui  out  1  immediate<<16 path.
- halted  out  1  FSM is in HALT.
- trap_cause  out  2  none(00), illegal opcode(01), memory timeout(10); sticky.

Behaviour:
- Reset: state=FETCH, wait counter=0, trap_cause=00. While rst=1, every output is 0. The first cycle after release is FETCH.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT. Encoding and constants come from the package.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in a cycle where mem_ready=1; then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEM_ADDR.
  - 000000 (R-type) → EXEC_R.
  - 001000 (addi), 001101 (ori), 001111 (lui) → EXEC_I.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - Any other opcode → HALT with trap_cause=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. ori=1 for opcode 001101; lui=1 for opcode 001111. → I_WB.
- I_WB: reg_write=1, reg_dst=0, with the same ori/lui values as EXEC_I → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- Memory handshake:
  - mem_read/mem_write are held constant until the cycle mem_ready=1.
  - mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on state exit.
  - When it reaches WAIT_LIMIT with mem_ready still 0, next state is HALT with trap_cause=10.
  - mem_ready=1 in the same cycle the limit is reached wins: the access completes and no trap is taken.
- HALT:
  - All enables are 0; halted=1.
  - Only rst exits HALT.
  - trap_cause holds its value until reset.
- Reset mid-operation: rst aborts any pending memory access. Outputs drop to 0 in the same cycle and memory requests are not re-issued.
- Outputs not listed for a state are 0.

Optional Feature:
- Macro INSTR_COUNT_EN.
  - Defined: adds output retired [CNT_W-1:0]. It resets to 0 and increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP. It wraps modulo 2^CNT_W and is frozen in HALT.
  - Undefined: no port and no counter logic.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_LUI.
  - ALUOp constants.
  - alu_src_b and pc_source encodings.
  - Trap-cause codes.
- One sub-module, mc_mem_wait: wait counter plus timeout compare, with inputs busy and mem_ready and output timeout.

Test Plan:
- rst=1 for 2 cycles then release, mem_ready=1 → first cycle FETCH with mem_read=1, ir_write=1, pc_write=1; all outputs 0 during reset.
- lw (opcode 100011), mem_ready low for 3 cycles in MEM_RD → FETCH(1)/DECODE/MEM_ADDR/MEM_RD×4/MEM_WB; mem_read held for 4 cycles; reg_write=1, mem_to_reg=1 exactly once.
- beq with zero=1, then with zero=0 → BRANCH cycle shows pc_write_cond=1, alu_op=01, pc_source=01 in both cases; return to FETCH next cycle.
- lui (001111) then ori (001101) → lui=1 in EXEC_I and I_WB only, and ori=1 likewise; reg_dst=0 and reg_write=1 in I_WB.
- Opcode 111111 in DECODE → HALT next cycle, halted=1, trap_cause=01; mem_ready pulses are ignored; rst returns to FETCH with trap_cause=00.
- WAIT_LIMIT=4, sw with mem_ready held 0 → HALT after 4 waiting cycles with trap_cause=10. Repeat with mem_ready=1 on the 4th cycle → no trap, next state FETCH. With INSTR_COUNT_EN defined, retired increments by 1.
